// File: rtl/ppi_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : ppi_event_capture
// Purpose  : Captures enabled PPI event pulses into a FIFO readable over PAR.
//            Define PPI_EVENT_CAPTURE_TIMESTAMP_EN to stamp entries [31:16].
// Revision : 1.0 - initial release
// ============================================================================
module ppi_event_capture #(
   parameter int NUM_PPI_CHANNELS      = 16,
   parameter int FIFO_DEPTH            = 8,
   parameter int PAR_AW                = 12,
   parameter int PAR_DW                = 32,
   parameter int PAR_WW                = 4,
   parameter int ID_EVENT_CAPTURE_BASE = 'h000
) (
   input  logic                        ckPar,
   input  logic                        arstPar,
   input  logic [NUM_PPI_CHANNELS-1:0] ppiBusProducer,
   input  logic [PAR_AW-1:0]           parAddr,
   input  logic [PAR_DW-1:0]           parDo,
   input  logic                        parRe,
   input  logic [PAR_WW-1:0]           parWe,
   output logic [PAR_DW-1:0]           parDi,
   output logic                        parDiSelect,
   output logic                        irqEventCapture
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [PAR_AW-1:0] c_ADDR_DATA   = PAR_AW'(ID_EVENT_CAPTURE_BASE + 'h000);
   localparam logic [PAR_AW-1:0] c_ADDR_STATUS = PAR_AW'(ID_EVENT_CAPTURE_BASE + 'h004);
   localparam logic [PAR_AW-1:0] c_ADDR_CHEN   = PAR_AW'(ID_EVENT_CAPTURE_BASE + 'h008);
   localparam logic [PAR_AW-1:0] c_ADDR_CLEAR  = PAR_AW'(ID_EVENT_CAPTURE_BASE + 'h00C);
   localparam logic [PAR_AW-1:0] c_ADDR_INTEN  = PAR_AW'(ID_EVENT_CAPTURE_BASE + 'h010);

   logic [NUM_PPI_CHANNELS-1:0] r_pending;
   logic [NUM_PPI_CHANNELS-1:0] r_chen;
   logic                        r_inten;
   logic                        r_overflow;
   logic                        r_merged;
   logic                        r_irq;
   logic [c_PTR_W-1:0]          r_wr_ptr;
   logic [c_PTR_W-1:0]          r_rd_ptr;
   logic [c_CNT_W-1:0]          r_count;
   logic [7:0]                  r_mem_idx [FIFO_DEPTH];

   logic                        w_hit_data, w_hit_status, w_hit_chen, w_hit_clear, w_hit_inten;
   logic                        w_wr, w_pop, w_flush, w_clr_flags;
   logic                        w_empty, w_full;
   logic                        w_push_vld, w_fire, w_drop, w_merge;
   logic [7:0]                  w_push_idx;
   logic [NUM_PPI_CHANNELS-1:0] w_push_oh;
   logic [NUM_PPI_CHANNELS-1:0] w_pulse;
   logic [NUM_PPI_CHANNELS-1:0] w_chen_nxt;
   logic [15:0]                 w_head_ts;
   logic [15:0]                 w_push_ts;
   logic [31:0]                 w_rdata;

   assign w_hit_data   = (parAddr == c_ADDR_DATA);
   assign w_hit_status = (parAddr == c_ADDR_STATUS);
   assign w_hit_chen   = (parAddr == c_ADDR_CHEN);
   assign w_hit_clear  = (parAddr == c_ADDR_CLEAR);
   assign w_hit_inten  = (parAddr == c_ADDR_INTEN);

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
   assign w_wr        = |parWe;
   assign w_pop       = parRe & w_hit_data & ~w_empty;
   assign w_flush     = w_wr & w_hit_clear & parWe[0] & parDo[0];
   assign w_clr_flags = w_wr & w_hit_clear & parWe[0] & parDo[1];

   // Lowest-index pending channel wins the single push slot this cycle
   always_comb begin
      w_push_idx = '0;
      w_push_oh  = '0;
      for (int i = NUM_PPI_CHANNELS - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_push_idx   = 8'(i);
            w_push_oh    = '0;
            w_push_oh[i] = 1'b1;
         end
      end
   end

   assign w_push_vld = |r_pending;
   assign w_fire     = w_push_vld & (~w_full | w_pop) & ~w_flush;
   assign w_drop     = w_push_vld & w_full & ~w_pop & ~w_flush;
   assign w_pulse    = ppiBusProducer & r_chen;
   assign w_merge    = |(w_pulse & r_pending & ~w_push_oh);

   always_comb begin
      w_chen_nxt = r_chen;
      for (int i = 0; i < NUM_PPI_CHANNELS; i++) begin
         if (parWe[i/8]) begin
            w_chen_nxt[i] = parDo[i];
         end
      end
   end

`ifdef PPI_EVENT_CAPTURE_TIMESTAMP_EN
   logic [15:0] r_ts;
   logic [15:0] r_mem_ts [FIFO_DEPTH];

   always_ff @(posedge ckPar or negedge arstPar) begin
      if (!arstPar) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + 16'd1;
      end
   end

   always_ff @(posedge ckPar) begin
      if (w_fire) begin
         r_mem_ts[r_wr_ptr] <= w_push_ts;
      end
   end

   assign w_push_ts = r_ts;
   assign w_head_ts = r_mem_ts[r_rd_ptr];
`else
   assign w_push_ts = 16'd0;
   assign w_head_ts = w_push_ts;
`endif

   always_ff @(posedge ckPar) begin
      if (w_fire) begin
         r_mem_idx[r_wr_ptr] <= w_push_idx;
      end
   end

   always_ff @(posedge ckPar or negedge arstPar) begin
      if (!arstPar) begin
         r_pending  <= '0;
         r_chen     <= '0;
         r_inten    <= 1'b0;
         r_overflow <= 1'b0;
         r_merged   <= 1'b0;
         r_irq      <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_irq <= r_inten & ~w_empty;

         if (w_wr & w_hit_chen) begin
            r_chen <= w_chen_nxt;
         end
         if (w_wr & w_hit_inten & parWe[0]) begin
            r_inten <= parDo[0];
         end

         if (w_flush) begin
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
         end else begin
            r_pending <= (r_pending & ~w_push_oh) | w_pulse;
            if (w_fire) begin
               r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_fire) - c_CNT_W'(w_pop);
         end

         // A same-cycle flag clear takes priority over a new flag event
         if (w_clr_flags) begin
            r_overflow <= 1'b0;
            r_merged   <= 1'b0;
         end else begin
            r_overflow <= r_overflow | w_drop;
            r_merged   <= r_merged | (w_merge & ~w_flush);
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if (parRe) begin
         if (w_hit_data && !w_empty) begin
            w_rdata = {w_head_ts, 1'b1, 7'b0, r_mem_idx[r_rd_ptr]};
         end else if (w_hit_status) begin
            w_rdata = {20'b0, r_merged, r_overflow, w_full, w_empty, 8'(r_count)};
         end else if (w_hit_chen) begin
            w_rdata = 32'(r_chen);
         end else if (w_hit_inten) begin
            w_rdata = {31'b0, r_inten};
         end
      end
   end

   assign parDi           = PAR_DW'(w_rdata);
   assign parDiSelect     = parRe & (w_hit_data | w_hit_status | w_hit_chen | w_hit_clear | w_hit_inten);
   assign irqEventCapture = r_irq;

endmodule
`default_nettype wire
